// File: rtl/nios_sys_pio_pkg.sv
// Shared constants for the Nios system PIO blocks: word address map and
// edge-capture mode encodings.
package nios_sys_pio_pkg;

   localparam logic [1:0] ADDR_DATA    = 2'd0;
   localparam logic [1:0] ADDR_DIR     = 2'd1;
   localparam logic [1:0] ADDR_IRQMASK = 2'd2;
   localparam logic [1:0] ADDR_EDGECAP = 2'd3;

   localparam int EDGE_RISE = 0;
   localparam int EDGE_FALL = 1;
   localparam int EDGE_ANY  = 2;

endpackage

// File: rtl/nios_sys_pio_debounce.sv
// One-bit debouncer: accepts a new level only after it has differed from the
// accepted level for DEBOUNCE consecutive cycles.
module nios_sys_pio_debounce #(
   parameter int DEBOUNCE = 1
) (
   input  logic clk,
   input  logic reset,
   input  logic settle_done,
   input  logic din,
   output logic dout,
   output logic dout_next
);

   localparam int              CW   = $clog2(DEBOUNCE + 1);
   localparam logic [CW-1:0]   LAST = CW'(DEBOUNCE - 1);

   logic [CW-1:0] cnt;
   logic [CW-1:0] cnt_next;

   // Before settle_done the accepted state tracks the synchronizer directly.
   always_comb begin
      cnt_next  = '0;
      dout_next = dout;
      if (!settle_done) begin
         dout_next = din;
      end else if (din != dout) begin
         if (cnt == LAST) begin
            dout_next = din;
         end else begin
            cnt_next = cnt + CW'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         dout <= 1'b0;
         cnt  <= '0;
      end else begin
         dout <= dout_next;
         cnt  <= cnt_next;
      end
   end

endmodule

// File: rtl/nios_sys_pio_encoder_in.sv
// Avalon-MM input PIO for encoder and limit-switch lines: synchronize,
// debounce, capture edges into sticky bits, and raise a maskable level irq.
module nios_sys_pio_encoder_in
   import nios_sys_pio_pkg::*;
#(
   parameter int WIDTH     = 8,
   parameter int DEBOUNCE  = 1,
   parameter int EDGE_TYPE = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [1:0]       address,
   input  logic             chipselect,
   input  logic             write_n,
   input  logic [31:0]      writedata,
   input  logic [WIDTH-1:0] in_port,
   output logic [31:0]      readdata,
   output logic             irq
);

   // Bus: a write is taken on any clk edge with chipselect=1 and write_n=0;
   // reads are combinational from address with no wait states.
   logic             wr;
   logic [WIDTH-1:0] sync0, sync1;
   logic [WIDTH-1:0] stable, stable_nxt;
   logic [WIDTH-1:0] irq_mask, mask_next;
   logic [WIDTH-1:0] edge_capture, ec_next;
   logic [WIDTH-1:0] clr, edges, rise, fall;
   logic [1:0]       settle;
   logic             settle_done;
   logic             unused_wd;

   assign wr          = chipselect & ~write_n;
   assign settle_done = (settle == 2'd3);
   assign unused_wd   = ^writedata;

   always_ff @(posedge clk) begin
      if (reset) begin
         sync0  <= '0;
         sync1  <= '0;
         settle <= 2'd0;
      end else begin
         sync0 <= in_port;
         sync1 <= sync0;
         if (!settle_done) begin
            settle <= settle + 2'd1;
         end
      end
   end

   for (genvar i = 0; i < WIDTH; i++) begin : gen_bit
      nios_sys_pio_debounce #(
         .DEBOUNCE(DEBOUNCE)
      ) u_db (
         .clk        (clk),
         .reset      (reset),
         .settle_done(settle_done),
         .din        (sync1[i]),
         .dout       (stable[i]),
         .dout_next  (stable_nxt[i])
      );
   end

   // Edges are suppressed while settling so reset values never look like inputs.
   always_comb begin
      rise  = stable_nxt & ~stable;
      fall  = ~stable_nxt & stable;
      edges = '0;
      if (settle_done) begin
         if (EDGE_TYPE == EDGE_RISE) begin
            edges = rise;
         end else if (EDGE_TYPE == EDGE_FALL) begin
            edges = fall;
         end else if (EDGE_TYPE == EDGE_ANY) begin
            edges = rise | fall;
         end
      end
   end

   assign clr       = (wr && address == ADDR_EDGECAP) ? writedata[WIDTH-1:0] : '0;
   assign ec_next   = (edge_capture & ~clr) | edges;
   assign mask_next = (wr && address == ADDR_IRQMASK) ? writedata[WIDTH-1:0] : irq_mask;

   always_ff @(posedge clk) begin
      if (reset) begin
         edge_capture <= '0;
         irq_mask     <= '0;
         irq          <= 1'b0;
      end else begin
         edge_capture <= ec_next;
         irq_mask     <= mask_next;
         irq          <= |(ec_next & mask_next);
      end
   end

   always_comb begin
      readdata = '0;
      case (address)
         ADDR_DATA:    readdata[WIDTH-1:0] = stable;
         ADDR_DIR:     readdata = '0;
         ADDR_IRQMASK: readdata[WIDTH-1:0] = irq_mask;
         ADDR_EDGECAP: readdata[WIDTH-1:0] = edge_capture;
         default:      readdata = '0;
      endcase
   end

endmodule

// File: tb/tb_nios_sys_pio_encoder_in.sv
// Bench for nios_sys_pio_encoder_in: two instances (slow rising-edge, fast
// any-edge) on a shared bus, checked against a behavioural model.
`timescale 1ns/1ps
module tb_nios_sys_pio_encoder_in;

   localparam int W   = 8;
   localparam int DB0 = 4;
   localparam int ET0 = 0;
   localparam int DB1 = 1;
   localparam int ET1 = 2;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic [1:0]    address = 2'd0;
   logic          chipselect = 1'b0;
   logic          write_n = 1'b1;
   logic [31:0]   writedata = '0;
   logic [W-1:0]  in_port = '0;
   logic [31:0]   rd0, rd1;
   logic          irq0, irq1;

   int errors = 0;
   int checks = 0;

   always #10 clk = ~clk;

   nios_sys_pio_encoder_in #(.WIDTH(W), .DEBOUNCE(DB0), .EDGE_TYPE(ET0)) dut0 (
      .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
      .write_n(write_n), .writedata(writedata), .in_port(in_port),
      .readdata(rd0), .irq(irq0)
   );

   nios_sys_pio_encoder_in #(.WIDTH(W), .DEBOUNCE(DB1), .EDGE_TYPE(ET1)) dut1 (
      .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
      .write_n(write_n), .writedata(writedata), .in_port(in_port),
      .readdata(rd1), .irq(irq1)
   );

   // Behavioural reference: two-stage input delay, settle window, and per-bit
   // run length of disagreement that must reach DEBOUNCE before acceptance.
   logic [W-1:0] m_s0[2], m_s1[2], m_st[2], m_ec[2], m_mask[2];
   int           m_run[2][W];
   int           m_settle[2];
   logic         m_irq[2];

   function automatic int db_of(input int k);
      return (k == 0) ? DB0 : DB1;
   endfunction

   function automatic int et_of(input int k);
      return (k == 0) ? ET0 : ET1;
   endfunction

   always @(posedge clk) begin : model
      for (int k = 0; k < 2; k++) begin
         automatic logic [W-1:0] st_n = m_st[k];
         automatic logic [W-1:0] edg = '0;
         automatic logic [W-1:0] clr_v, ec_n, mk_n, ups, downs;
         automatic int run_n[W];
         automatic bit wr = chipselect && !write_n;
         if (reset) begin
            m_s0[k] <= '0; m_s1[k] <= '0; m_st[k] <= '0;
            m_ec[k] <= '0; m_mask[k] <= '0; m_irq[k] <= 1'b0;
            m_settle[k] <= 0;
            for (int b = 0; b < W; b++) m_run[k][b] <= 0;
         end else begin
            for (int b = 0; b < W; b++) run_n[b] = 0;
            if (m_settle[k] < 3) begin
               st_n = m_s1[k];
            end else begin
               for (int b = 0; b < W; b++) begin
                  if (m_s1[k][b] != m_st[k][b]) begin
                     run_n[b] = m_run[k][b] + 1;
                     if (run_n[b] >= db_of(k)) begin
                        st_n[b]  = m_s1[k][b];
                        run_n[b] = 0;
                     end
                  end
               end
               ups   = st_n & ~m_st[k];
               downs = m_st[k] & ~st_n;
               edg   = (et_of(k) == 0) ? ups : (et_of(k) == 1) ? downs : (ups | downs);
            end
            clr_v = (wr && address == 2'd3) ? writedata[W-1:0] : '0;
            ec_n  = (m_ec[k] & ~clr_v) | edg;
            mk_n  = (wr && address == 2'd2) ? writedata[W-1:0] : m_mask[k];
            m_st[k]   <= st_n;
            m_ec[k]   <= ec_n;
            m_mask[k] <= mk_n;
            m_irq[k]  <= |(ec_n & mk_n);
            m_s1[k]   <= m_s0[k];
            m_s0[k]   <= in_port;
            m_settle[k] <= (m_settle[k] < 3) ? m_settle[k] + 1 : 3;
            for (int b = 0; b < W; b++) m_run[k][b] <= run_n[b];
         end
      end
   end

   function automatic logic [31:0] exp_rd(input int k, input int a);
      case (a)
         0:       return 32'(m_st[k]);
         2:       return 32'(m_mask[k]);
         3:       return 32'(m_ec[k]);
         default: return 32'd0;
      endcase
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic peek(input int k, input logic [1:0] a, output logic [31:0] v);
      address = a;
      #1;
      v = (k == 0) ? rd0 : rd1;
   endtask

   task automatic check_all();
      for (int a = 0; a < 4; a++) begin
         address = 2'(a);
         #1;
         check($sformatf("model_rd0_a%0d", a), rd0, exp_rd(0, a));
         check($sformatf("model_rd1_a%0d", a), rd1, exp_rd(1, a));
      end
      check("model_irq0", 32'(irq0), 32'(m_irq[0]));
      check("model_irq1", 32'(irq1), 32'(m_irq[1]));
      address = 2'd0;
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(negedge clk);
         check_all();
      end
   endtask

   task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
      address    = a;
      writedata  = d;
      chipselect = 1'b1;
      write_n    = 1'b0;
      @(negedge clk);
      chipselect = 1'b0;
      write_n    = 1'b1;
   endtask

   logic [31:0] v;
   int r;

   initial begin
      // Reset with all inputs high; data reads FF once settled, no edges.
      in_port = 8'hFF;
      reset   = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      step(3);
      peek(0, 2'd0, v); check("settle_data0", v, 32'h0000_00FF);
      peek(1, 2'd0, v); check("settle_data1", v, 32'h0000_00FF);
      peek(0, 2'd3, v); check("settle_ec0", v, 32'h0);
      check("settle_irq0", 32'(irq0), 32'h0);

      // Rising edge latency on the DEBOUNCE=4 instance.
      in_port = 8'h00;
      step(10);
      bus_write(2'd3, 32'hFF);
      bus_write(2'd2, 32'h01);
      in_port = 8'h01;
      step(5);
      peek(0, 2'd0, v); check("lat_early_data0", 32'(v[0]), 32'h0);
      check("lat_early_irq0", 32'(irq0), 32'h0);
      step(1);
      peek(0, 2'd0, v); check("lat_data0", v, 32'h01);
      peek(0, 2'd3, v); check("lat_ec0", v, 32'h01);
      check("lat_irq0", 32'(irq0), 32'h1);

      // Three-cycle glitch is rejected by DEBOUNCE=4.
      in_port = 8'h00;
      step(10);
      bus_write(2'd3, 32'hFF);
      step(2);
      in_port = 8'h01;
      step(3);
      in_port = 8'h00;
      step(10);
      peek(0, 2'd0, v); check("glitch_data0", v, 32'h0);
      peek(0, 2'd3, v); check("glitch_ec0", v, 32'h0);
      check("glitch_irq0", 32'(irq0), 32'h0);

      // Write-1-to-clear, then a clear colliding with a new edge.
      in_port = 8'h05;
      step(10);
      peek(0, 2'd3, v); check("w1c_pre_ec0", v, 32'h05);
      bus_write(2'd3, 32'h04);
      peek(0, 2'd3, v); check("w1c_ec0", v, 32'h01);
      in_port = 8'h01;
      step(10);
      in_port = 8'h05;
      step(5);
      bus_write(2'd3, 32'h04);
      peek(0, 2'd3, v); check("set_wins_ec0", v, 32'h05);
      step(2);

      // Any-edge capture with irq masked, then unmask.
      bus_write(2'd2, 32'h00);
      bus_write(2'd3, 32'hFF);
      in_port = in_port ^ 8'h08;
      step(4);
      in_port = in_port ^ 8'h08;
      step(4);
      peek(1, 2'd3, v); check("any_ec1_bit3", 32'(v[3]), 32'h1);
      check("any_irq1_masked", 32'(irq1), 32'h0);
      bus_write(2'd2, 32'h08);
      check("any_irq1_unmasked", 32'(irq1), 32'h1);
      step(1);

      // Randomized traffic including unused-address writes and mid-run resets.
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 3) == 0) in_port = W'($urandom);
         r = $urandom_range(0, 59);
         if (r < 4) begin
            bus_write(2'd2, $urandom);
            check_all();
         end else if (r < 8) begin
            bus_write(2'd3, $urandom);
            check_all();
         end else if (r < 10) begin
            bus_write(2'($urandom_range(0, 1)), $urandom);
            check_all();
         end else if (r == 10) begin
            reset = 1'b1;
            @(negedge clk);
            reset = 1'b0;
            check_all();
         end else begin
            step(1);
         end
      end
      step(10);

      // Reset while edge_capture is full and irq is high.
      bus_write(2'd2, 32'hFF);
      in_port = ~in_port;
      step(6);
      peek(1, 2'd3, v); check("pre_rst_ec1", v, 32'hFF);
      check("pre_rst_irq1", 32'(irq1), 32'h1);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      peek(1, 2'd0, v); check("rst_data1", v, 32'h0);
      peek(1, 2'd2, v); check("rst_mask1", v, 32'h0);
      peek(1, 2'd3, v); check("rst_ec1", v, 32'h0);
      check("rst_irq1", 32'(irq1), 32'h0);
      check("rst_irq0", 32'(irq0), 32'h0);
      step(6);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
